fu_result_queue: RTL and testbench

Parametrised result queue between a functional unit's final stage and its result bus (CDB for ALU/branch FUs, address bus for the memory-address FU). It holds completed results (value, ROB tag, exception, redirect-mispredict) in FIFO order and presents the head entry to the bus arbiter. It adds depth/width parameters, occupancy and backpressure flags to stall reservation-station issue, a pipeline flush, a sticky overflow error, and an optional same-cycle empty bypass.

---
 rtl/fu_result_queue.sv | 132 +++++++++++++
 tb/tb_fu_result_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_result_queue.sv
// Result FIFO between a functional unit's last stage and its result bus.
// Optional same-cycle empty bypass is enabled by defining FU_RESULT_QUEUE_BYPASS_EN.
module fu_result_queue #(
  parameter int XLEN               = 32,
  parameter int TAG_WIDTH          = 32,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_MARGIN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [XLEN-1:0]              value,
  input  logic [TAG_WIDTH-1:0]         tag,
  input  logic                         exception,
  input  logic                         redirect_mispredicted,
  input  logic                         write_en,
  input  logic                         flush,
  input  logic                         data_bus_permit,
  output logic                         not_empty,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output wire  [XLEN-1:0]              data_bus_data,
  output wire  [TAG_WIDTH-1:0]         data_bus_tag,
  output wire                          data_bus_exception,
  output wire                          data_bus_redirect_mispredicted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(DEPTH - ALMOST_FULL_MARGIN);

  logic [XLEN-1:0]      value_mem_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem_q   [DEPTH];
  logic                 exc_mem_q   [DEPTH];
  logic                 red_mem_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic q_empty, bypass, bypass_take, enq, deq;

  assign q_empty = (count_q == '0);

`ifdef FU_RESULT_QUEUE_BYPASS_EN
  assign bypass = q_empty && !flush && write_en;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result granted in the same cycle goes straight to the bus and is never stored.
  assign bypass_take = bypass && data_bus_permit;
  assign enq         = write_en && (!full || data_bus_permit) && !bypass_take;
  assign deq         = data_bus_permit && !q_empty;

  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign not_empty   = !q_empty || bypass;
  assign count       = count_q;
  assign overflow    = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq && !deq)      count_d = count_q + CNT_W'(1);
      else if (deq && !enq) count_d = count_q - CNT_W'(1);
      if (write_en && full && !data_bus_permit) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        value_mem_q[i] <= '0;
        tag_mem_q[i]   <= '0;
        exc_mem_q[i]   <= 1'b0;
        red_mem_q[i]   <= 1'b0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (enq && !flush) begin
        value_mem_q[wr_ptr_q] <= value;
        tag_mem_q[wr_ptr_q]   <= tag;
        exc_mem_q[wr_ptr_q]   <= exception;
        red_mem_q[wr_ptr_q]   <= redirect_mispredicted;
      end
    end
  end

  logic [XLEN-1:0]      head_value;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 head_exc, head_red;

  always_comb begin
    head_value = value_mem_q[rd_ptr_q];
    head_tag   = tag_mem_q[rd_ptr_q];
    head_exc   = exc_mem_q[rd_ptr_q];
    head_red   = red_mem_q[rd_ptr_q];
    if (bypass_take) begin
      head_value = value;
      head_tag   = tag;
      head_exc   = exception;
      head_red   = redirect_mispredicted;
    end
  end

  // Shared bus: released whenever the arbiter has not granted this queue.
  assign data_bus_data                  = data_bus_permit ? head_value : {XLEN{1'bz}};
  assign data_bus_tag                   = data_bus_permit ? head_tag   : {TAG_WIDTH{1'bz}};
  assign data_bus_exception             = data_bus_permit ? head_exc   : 1'bz;
  assign data_bus_redirect_mispredicted = data_bus_permit ? head_red   : 1'bz;

endmodule

// File: tb/tb_fu_result_queue.sv
// Self-checking bench for fu_result_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fu_result_queue;
  localparam int XLEN      = 32;
  localparam int TAG_WIDTH = 32;
  localparam int DEPTH     = 4;
  localparam int MARGIN    = 1;
  localparam int CNT_W     = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [TAG_WIDTH-1:0] tag;
    logic                 exc;
    logic                 red;
  } res_t;

  logic clk = 1'b0;
  logic reset, write_en, flush, data_bus_permit, exception, redirect_mispredicted;
  logic [XLEN-1:0]      value;
  logic [TAG_WIDTH-1:0] tag;
  logic                 not_empty, full, almost_full, overflow;
  logic [CNT_W-1:0]     count;
  wire  [XLEN-1:0]      data_bus_data;
  wire  [TAG_WIDTH-1:0] data_bus_tag;
  wire                  data_bus_exception, data_bus_redirect_mispredicted;

  fu_result_queue #(
    .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .tag(tag), .exception(exception),
    .redirect_mispredicted(redirect_mispredicted), .write_en(write_en), .flush(flush),
    .data_bus_permit(data_bus_permit), .not_empty(not_empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .data_bus_data(data_bus_data), .data_bus_tag(data_bus_tag),
    .data_bus_exception(data_bus_exception),
    .data_bus_redirect_mispredicted(data_bus_redirect_mispredicted)
  );

  always #5 clk = ~clk;

  res_t model_q[$];
  logic model_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [XLEN-1:0] val, input logic [TAG_WIDTH-1:0] tg,
                       input logic pm, input logic fl);
    write_en              = we;
    value                 = val;
    tag                   = tg;
    exception             = tg[0];
    redirect_mispredicted = tg[1];
    data_bus_permit       = pm;
    flush                 = fl;
  endtask

  // Compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int   n;
    logic byp;
    res_t cur;
    logic [XLEN-1:0]      zv;
    logic [TAG_WIDTH-1:0] zt;
    zv = 'z;
    zt = 'z;
    @(negedge clk);
    n = model_q.size();
`ifdef FU_RESULT_QUEUE_BYPASS_EN
    byp = (n == 0) && !flush && write_en;
`else
    byp = 1'b0;
`endif
    cur = '{value: value, tag: tag, exc: exception, red: redirect_mispredicted};
    chk("count", 64'(count), 64'(n));
    chk("not_empty", 64'(not_empty), 64'((n != 0) || byp));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(n >= DEPTH - MARGIN));
    chk("overflow", 64'(overflow), 64'(model_ovf));
    if (!data_bus_permit) begin
      chk("bus_data_z", 64'(data_bus_data), 64'(zv));
      chk("bus_tag_z", 64'(data_bus_tag), 64'(zt));
    end else if (byp || n != 0) begin
      res_t h;
      h = byp ? cur : model_q[0];
      chk("bus_data", 64'(data_bus_data), 64'(h.value));
      chk("bus_tag", 64'(data_bus_tag), 64'(h.tag));
      chk("bus_exc", 64'(data_bus_exception), 64'(h.exc));
      chk("bus_red", 64'(data_bus_redirect_mispredicted), 64'(h.red));
    end
    @(posedge clk);
    if (reset) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else if (!(byp && data_bus_permit)) begin
      if (write_en && n == DEPTH && !data_bus_permit) model_ovf = 1'b1;
      if (data_bus_permit && n != 0) void'(model_q.pop_front());
      if (write_en && (n < DEPTH || data_bus_permit)) model_q.push_back(cur);
    end
    #1;
  endtask

  task automatic put(input logic we, input int tg, input logic pm, input logic fl);
    drive(we, 32'hA5000000 ^ 32'(tg * 32'h00010101), 32'(tg), pm, fl);
    cycle();
  endtask

  initial begin
    model_ovf = 1'b0;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    put(1'b0, 0, 1'b0, 1'b0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_not_empty", 64'(not_empty), 64'd0);

    // Permit while empty after reset drives the cleared head slot; state unchanged.
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    chk("empty_permit_tag", 64'(data_bus_tag), 64'd0);
    cycle();
    chk("empty_permit_count", 64'(count), 64'd0);

    // Three writes, then drain in order.
    for (int i = 1; i <= 3; i++) put(1'b1, i, 1'b0, 1'b0);
    chk("tp1_count", 64'(count), 64'd3);
    chk("tp1_almost_full", 64'(almost_full), 64'd1);
    chk("tp1_full", 64'(full), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #3;
      chk("tp1_drain_tag", 64'(data_bus_tag), 64'(i));
      cycle();
    end
    chk("tp1_end_count", 64'(count), 64'd0);
    chk("tp1_end_not_empty", 64'(not_empty), 64'd0);

    // Fill, overflow on tag 9, drain 1..4.
    for (int i = 1; i <= 4; i++) put(1'b1, i, 1'b0, 1'b0);
    put(1'b1, 9, 1'b0, 1'b0);
    chk("tp2_full", 64'(full), 64'd1);
    chk("tp2_overflow", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #3;
      chk("tp2_drain_tag", 64'(data_bus_tag), 64'(i));
      cycle();
    end
    chk("tp2_empty", 64'(not_empty), 64'd0);

    // Full with simultaneous write and permit.
    for (int i = 1; i <= 4; i++) put(1'b1, i, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 32'd5, 1'b1, 1'b0);
    #3;
    chk("tp3_bus_tag", 64'(data_bus_tag), 64'd1);
    cycle();
    chk("tp3_count", 64'(count), 64'd4);
    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #3;
      chk("tp3_drain_tag", 64'(data_bus_tag), 64'(i));
      cycle();
    end

    // Flush beats same-cycle write and permit; overflow stays sticky.
    for (int i = 1; i <= 3; i++) put(1'b1, i, 1'b0, 1'b0);
    drive(1'b1, 32'h77, 32'd8, 1'b1, 1'b1);
    #3;
    chk("tp4_flush_bus_tag", 64'(data_bus_tag), 64'd1);
    cycle();
    chk("tp4_count", 64'(count), 64'd0);
    chk("tp4_not_empty", 64'(not_empty), 64'd0);
    chk("tp4_overflow", 64'(overflow), 64'd1);

    // Staggered write/permit pairs wrap the pointers.
    for (int i = 0; i <= 10; i++) put(i < 10, 20 + i, i > 0, 1'b0);
    chk("tp5_count", 64'(count), 64'd0);

    // Empty-queue write with permit.
    drive(1'b1, 32'hDEADBEEF, 32'd7, 1'b1, 1'b0);
    #3;
`ifdef FU_RESULT_QUEUE_BYPASS_EN
    chk("tp6_bypass_data", 64'(data_bus_data), 64'hDEADBEEF);
    chk("tp6_bypass_tag", 64'(data_bus_tag), 64'd7);
    chk("tp6_not_empty", 64'(not_empty), 64'd1);
    cycle();
    chk("tp6_count", 64'(count), 64'd0);
`else
    chk("tp6_not_empty", 64'(not_empty), 64'd0);
    cycle();
    chk("tp6_count", 64'(count), 64'd1);
`endif
    put(1'b0, 0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic we, pm, fl;
      we = ($urandom_range(0, 2) != 0);
      pm = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 24) == 0);
      if (fl && we && !pm && model_q.size() == DEPTH) we = 1'b0;
      drive(we, $urandom, $urandom, pm, fl);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
